instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
// - RV32 fetch stage, upstream of decode/immediate generation: owns the PC, requests words from
//   instruction memory and hands {instruction, pc} to decode via a valid/ready handshake.
// - Single outstanding imem request; redirect (branch/jump) flushes in-flight and held fetches.
// PARAMETERS
// - RESET_PC  32'h0000_0000  first fetch address after reset (bits [1:0] must be 0)
// PORTS
// - clk              in   1   clock, all state on rising edge
// - reset            in   1   asynchronous, active-low reset
// - imem_req_valid   out  1   fetch request valid
// - imem_req_ready   in   1   imem accepts request this cycle
// - imem_req_addr    out  32  word-aligned fetch address
// - imem_rsp_valid   in   1   response data valid (only ever for an accepted request)
// - imem_rsp_data    in   32  fetched instruction word
// - redirect_valid   in   1   redirect fetch to redirect_pc this cycle
// - redirect_pc      in   32  redirect target; bits [1:0] ignored (forced 0)
// - if_valid         out  1   instruction/pc valid to decode
// - if_ready         in   1   decode accepts this cycle
// - if_instruction   out  32  instruction word to decode
// - if_pc            out  32  address of if_instruction
// BEHAVIOUR
// - Registers: pc (next fetch addr), pc_inflight, kill, state, if_* output regs.
// - Reset (reset=0, async): state=S_IDLE, pc=RESET_PC, kill=0, if_valid=0, if_instruction=0,
//   if_pc=0; imem_req_valid=0, imem_req_addr=pc.
// - imem_req_valid=1 only in S_REQ; imem_req_addr=pc always. Request handshake = valid & ready.
// - S_IDLE: -> S_REQ next cycle (first request one cycle after reset release).
// - S_REQ: on handshake: pc_inflight<=pc, pc<=pc+4, -> S_WAIT.
//   redirect without handshake: pc<={redirect_pc[31:2],2'b00}, stay S_REQ (addr changes
//   next cycle; only permitted case of addr change while valid).
//   redirect with handshake: request goes out with old addr, kill<=1, pc<=redirect target, -> S_WAIT.
// - S_WAIT: rsp_valid & !kill & !redirect: if_instruction<=rsp_data, if_pc<=pc_inflight,
//   if_valid<=1, -> S_HOLD.
//   rsp_valid & (kill | redirect): response discarded, kill<=0, -> S_REQ.
//   redirect & !rsp_valid: kill<=1, pc<=redirect target, stay S_WAIT.
//   Redirect also updates pc in every case above.
// - S_HOLD: if_valid=1, if_* stable until accepted. if_ready (no redirect): if_valid<=0, -> S_REQ.
//   redirect (overrides if_ready): if_valid<=0, pc<=redirect target, -> S_REQ; held instr dropped.
// - Redirect in S_IDLE: pc<=redirect target, -> S_REQ.
// - PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
// - Latency: req accept -> rsp (imem-defined, >=1 cycle) -> if_valid next edge; min 3 cycles
//   per instruction with ready imem and decode. No combinational path from inputs to outputs.
// - Reset mid-operation: all state cleared immediately; any later imem response before the
//   first new request is ignored (state is not S_WAIT).
// TESTING
// - Reset release, imem_req_ready=1, rsp 1 cycle after accept with 32'h0050_0093, if_ready=1
//   -> req addr 0x0; if_valid=1, if_pc=0x0, if_instruction=0x0050_0093; next req addr 0x4.
// - Backpressure: if_ready=0 for 5 cycles in S_HOLD -> if_valid/if_pc/if_instruction stable,
//   imem_req_valid=0; if_ready=1 -> if_valid drops next cycle, next req addr pc+4.
// - Redirect to 0x100 in S_WAIT, rsp 3 cycles later -> rsp discarded, if_valid never rises,
//   next req addr 0x100, following delivered if_pc=0x100.
// - Redirect to 0x200 same cycle as req handshake at 0x8 -> rsp for 0x8 discarded,
//   next req addr 0x200.
// - Redirect to 0x103 -> req addr 0x100; redirect to 0xFFFF_FFFC -> req 0xFFFF_FFFC then 0x0.
// - Assert reset in S_WAIT at req 0x40 -> if_valid=0 immediately; after release first req
//   addr RESET_PC; stale rsp_valid during S_IDLE produces no if_valid.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// Fetch stage bus bundle: imem request/response,
// redirect input and the decode-side handshake.
interface instruction_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    output if_instruction,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    input  if_instruction,
    input  if_pc,
    output if_ready
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// RV32 fetch stage: owns the PC, one outstanding
// imem request, redirect flushes in-flight/held words.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                        clk,
  input logic                        reset,
  instruction_fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_inflight;
  logic        kill;
  logic        ifv;
  logic [31:0] ifi;
  logic [31:0] ifp;

  logic        hs;
  logic        redir;
  logic        rsp;
  logic [31:0] tgt;
  logic        unused_ok;

  assign hs        = (state == S_REQ) && bus.imem_req_ready;
  assign redir     = bus.redirect_valid;
  assign rsp       = bus.imem_rsp_valid;
  assign tgt       = {bus.redirect_pc[31:2], 2'b00};
  assign unused_ok = ^bus.redirect_pc[1:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; redirect sends HOLD/IDLE back to REQ
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ:  if (hs) state_nx = S_WAIT;
      S_WAIT: if (rsp)
                state_nx = (kill || redir) ? S_REQ : S_HOLD;
      S_HOLD: if (redir || bus.if_ready) state_nx = S_REQ;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs: request only in S_REQ, decode side from regs
  always_comb begin
    bus.imem_req_valid = (state == S_REQ);
    bus.imem_req_addr  = pc;
    bus.if_valid       = ifv;
    bus.if_instruction = ifi;
    bus.if_pc          = ifp;
  end

  // PC, kill flag and decode output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      pc_inflight <= 32'h0;
      kill        <= 1'b0;
      ifv         <= 1'b0;
      ifi         <= 32'h0;
      ifp         <= 32'h0;
    end else begin
      if (redir)   pc <= tgt;
      else if (hs) pc <= pc + 32'd4;

      if (hs) pc_inflight <= pc;

      unique case (1'b1)
        hs:
          kill <= redir;
        (state == S_WAIT) && rsp:
          kill <= 1'b0;
        (state == S_WAIT) && redir && !rsp:
          kill <= 1'b1;
        default: ;
      endcase

      if ((state == S_WAIT) && rsp && !kill && !redir) begin
        ifv <= 1'b1;
        ifi <= bus.imem_rsp_data;
        ifp <= pc_inflight;
      end else if ((state == S_HOLD) &&
                   (redir || bus.if_ready)) begin
        ifv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for the fetch stage: expected
// requests/deliveries queued, monitor pops on handshakes.
module tb_instruction_fetch_stage;

  logic clk;
  logic rst_n;

  instruction_fetch_stage_if bus();

  instruction_fetch_stage #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] exp_req[$];
  logic [63:0] exp_if[$];

  int rsp_delay = 1;
  int stale_n   = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    word = (a == 32'h0) ? 32'h0050_0093 : {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  // imem model: answers each accepted request after rsp_delay
  initial begin : imem_model
    bit          hs_s;
    bit          pend;
    int          cnt;
    int          stale_seen;
    logic [31:0] a_s;
    logic [31:0] paddr;
    pend = 0; cnt = 0; stale_seen = 0;
    hs_s = 0; a_s = 0; paddr = 0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      hs_s = rst_n && bus.imem_req_valid && bus.imem_req_ready;
      a_s  = bus.imem_req_addr;
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (!rst_n) pend = 0;
      if (hs_s) begin
        pend  = 1;
        cnt   = rsp_delay;
        paddr = a_s;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = word(paddr);
          pend = 0;
        end
      end
      if (stale_n > stale_seen) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_0BAD;
        stale_seen++;
      end
    end
  end

  // Monitor: compare every request and delivery handshake
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
        if (exp_req.size() == 0)
          chk("unexpected_req", bus.imem_req_addr, 32'hFFFF_FFFF);
        else
          chk("req_addr", bus.imem_req_addr, exp_req.pop_front());
      end
      if (rst_n && bus.if_valid && bus.if_ready) begin
        if (exp_if.size() == 0) begin
          chk("unexpected_if_pc", bus.if_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_if.pop_front();
          chk("if_pc", bus.if_pc, e[63:32]);
          chk("if_instr", bus.if_instruction, e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  // One request accepted at addr a; optional redirect same cycle
  task automatic issue(input logic [31:0] a, input bit dlv,
                       input bit rd, input logic [31:0] rpc);
    int n;
    exp_req.push_back(a);
    if (dlv) exp_if.push_back({a, word(a)});
    n = 0;
    while (!bus.imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk("req_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    bus.imem_req_ready = 1'b1;
    if (rd) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = rpc;
    end
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_if.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain", exp_if.size(), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instruction, 32'h0);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    tick();
    rst_n = 1'b1;

    // Basic fetch at reset PC
    issue(32'h0, 1, 0, 32'h0);
    drain();

    // Backpressure in HOLD
    bus.if_ready = 1'b0;
    issue(32'h4, 1, 0, 32'h0);
    n = 0;
    while (!bus.if_valid && n < 20) begin
      tick();
      n++;
    end
    chk("hold_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("bp_pc", bus.if_pc, 32'h4);
      chk("bp_instr", bus.if_instruction, word(32'h4));
      chk("bp_req", {31'b0, bus.imem_req_valid}, 32'd0);
    end
    tick();
    bus.if_ready = 1'b1;
    tick();
    chk("bp_drop", {31'b0, bus.if_valid}, 32'd0);
    chk("bp_nreq", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("bp_naddr", bus.imem_req_addr, 32'h8);

    // Redirect while waiting; slow response discarded
    rsp_delay = 3;
    issue(32'h8, 0, 0, 32'h0);
    redirect(32'h100);
    rsp_delay = 1;
    issue(32'h100, 1, 0, 32'h0);
    drain();

    // Redirect in same cycle as handshake at 0x8
    redirect(32'h8);
    issue(32'h8, 0, 1, 32'h200);
    issue(32'h200, 1, 0, 32'h0);
    drain();

    // Misaligned target and PC wrap
    redirect(32'h103);
    issue(32'h100, 1, 0, 32'h0);
    drain();
    redirect(32'hFFFF_FFFC);
    issue(32'hFFFF_FFFC, 1, 0, 32'h0);
    drain();
    issue(32'h0, 1, 0, 32'h0);
    drain();

    // Redirect drops held instruction
    bus.if_ready = 1'b0;
    issue(32'h4, 0, 0, 32'h0);
    n = 0;
    while (!bus.if_valid && n < 20) begin
      tick();
      n++;
    end
    chk("hold2_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    redirect(32'h300);
    chk("hold_redir_drop", {31'b0, bus.if_valid}, 32'd0);
    chk("hold_redir_addr", bus.imem_req_addr, 32'h300);
    bus.if_ready = 1'b1;
    issue(32'h300, 1, 0, 32'h0);
    drain();

    // Reset while waiting on 0x40
    redirect(32'h40);
    rsp_delay = 5;
    issue(32'h40, 0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("mid_rst_addr", bus.imem_req_addr, 32'h0);
    stale_n = 4;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("idle_if_valid", {31'b0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0);
    repeat (4) tick();
    chk("stale_if_valid", {31'b0, bus.if_valid}, 32'd0);
    rsp_delay = 1;
    issue(32'h0, 1, 0, 32'h0);
    drain();

    repeat (3) tick();
    chk("req_q_empty", exp_req.size(), 32'd0);
    chk("if_q_empty", exp_if.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
